pacoblaze_intc: RTL

Prioritised interrupt controller that sits between up to eight on-board interrupt sources and the single `interrupt`/`interrupt_ack` pair of a `pacoblaze` core. It detects source rising edges, holds them as pending, and arbitrates among the enabled ones. It drives `interrupt` with the handshake the core expects and latches the serviced vector. Firmware reads and writes its registers through the core's port bus (`port_id`, `write_strobe`, `out_port`, `in_port`).

---
 rtl/pacoblaze_intc_pkg.sv | 19 +
 rtl/pacoblaze_intc_prio.sv | 31 +++
 rtl/pacoblaze_intc.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pacoblaze_intc_pkg.sv
// Shared definitions for pacoblaze_intc: register offsets, CTRL bit positions, FSM states.
// Pure declarations, no logic.
package pacoblaze_intc_pkg;

    localparam logic [1:0] INTC_PEND = 2'd0;
    localparam logic [1:0] INTC_MASK = 2'd1;
    localparam logic [1:0] INTC_VEC  = 2'd2;
    localparam logic [1:0] INTC_CTRL = 2'd3;

    localparam int CTRL_GIE = 0;
    localparam int CTRL_EOI = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

endpackage

// File: rtl/pacoblaze_intc_prio.sv
// Combinational priority encoder: the first set request at or after base (wrapping) wins.
// Zero latency; base must be below NUM_SRC.
module pacoblaze_intc_prio #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [2:0]         base,
    output logic               vld,
    output logic [2:0]         idx
);

    logic [3:0] pos;

    // Walk from the farthest position back to base so the nearest hit is written last.
    always_comb begin
        vld = 1'b0;
        idx = 3'd0;
        pos = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            pos = {1'b0, base} + 4'(i);
            if (pos >= 4'(NUM_SRC)) begin
                pos = pos - 4'(NUM_SRC);
            end
            if (req[pos[2:0]]) begin
                vld = 1'b1;
                idx = pos[2:0];
            end
        end
    end

endmodule

// File: rtl/pacoblaze_intc.sv
// Edge-triggered, prioritised interrupt controller for a pacoblaze core; port-bus registers PEND/MASK/VEC/CTRL.
// PACOBLAZE_INTC_RR_EN selects rotating priority after the last serviced source; default is fixed, index 0 highest.
import pacoblaze_intc_pkg::*;

module pacoblaze_intc #(
    parameter int          NUM_SRC   = 8,
    parameter logic [7:0]  BASE_PORT = 8'h40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         port_id,
    input  logic               write_strobe,
    input  logic [7:0]         out_port,
    output logic [7:0]         rd_data,
    output logic               interrupt,
    input  logic               interrupt_ack
);

    logic [NUM_SRC-1:0] src_q, pend_q, pend_d, mask_q, cand;
    logic [NUM_SRC-1:0] edge_set, w1c_clr, eoi_clr;
    logic               arm_q, gie_q;
    logic [2:0]         vec_q, vec_d, base, win_idx;
    logic               win_vld;
    intc_state_e        state_q, state_d;
    logic [7:0]         rd_data_q, rd_data_d, pend8, mask8;
    logic               hit, wr_en, eoi_wr, eoi_take;
    logic [1:0]         off;

    assign hit      = (port_id[7:2] == BASE_PORT[7:2]);
    assign off      = port_id[1:0];
    assign wr_en    = write_strobe && hit;
    assign eoi_wr   = wr_en && (off == INTC_CTRL) && out_port[CTRL_EOI];
    assign eoi_take = eoi_wr && (state_q == ST_SERVICE);

    // arm_q blanks edge detection for the first cycle so a source held high through reset is not seen as an edge.
    assign edge_set = irq_src & ~src_q & {NUM_SRC{arm_q}};
    assign cand     = pend_q & mask_q & {NUM_SRC{gie_q}};

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            w1c_clr[i] = wr_en && (off == INTC_PEND) && out_port[i];
            eoi_clr[i] = eoi_take && (vec_q == 3'(i));
        end
        pend_d = (pend_q & ~(w1c_clr | eoi_clr)) | edge_set;
    end

`ifdef PACOBLAZE_INTC_RR_EN
    logic [2:0] last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 3'(NUM_SRC - 1);
        end else if (eoi_take) begin
            last_q <= vec_q;
        end
    end

    assign base = (last_q == 3'(NUM_SRC - 1)) ? 3'd0 : last_q + 3'd1;
`else
    assign base = 3'd0;
`endif

    pacoblaze_intc_prio #(.NUM_SRC(NUM_SRC)) u_prio (
        .req  (cand),
        .base (base),
        .vld  (win_vld),
        .idx  (win_idx)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    vec_d   = win_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (interrupt_ack) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pend8                = '0;
        mask8                = '0;
        pend8[NUM_SRC-1:0]   = pend_q;
        mask8[NUM_SRC-1:0]   = mask_q;
        rd_data_d            = '0;
        if (hit) begin
            case (off)
                INTC_PEND: rd_data_d = pend8;
                INTC_MASK: rd_data_d = mask8;
                INTC_VEC:  rd_data_d = {(state_q == ST_SERVICE), 4'b0000, vec_q};
                default:   rd_data_d = {7'b0000000, gie_q};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q     <= '0;
            arm_q     <= 1'b0;
            pend_q    <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            vec_q     <= 3'd0;
            state_q   <= ST_IDLE;
            rd_data_q <= 8'h00;
        end else begin
            src_q     <= irq_src;
            arm_q     <= 1'b1;
            pend_q    <= pend_d;
            vec_q     <= vec_d;
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            if (wr_en && (off == INTC_MASK)) begin
                mask_q <= out_port[NUM_SRC-1:0];
            end
            if (wr_en && (off == INTC_CTRL)) begin
                gie_q <= out_port[CTRL_GIE];
            end
        end
    end

    assign interrupt = (state_q == ST_REQ);
    assign rd_data   = rd_data_q;

endmodule
